// File: rtl/camera_capture_scheduler.sv
// Round-robin frame scheduler: grants one camera PHY at a time onto the shared DMA path,
// counts beats/lines of the granted frame and reports per-frame completion status.
module camera_capture_scheduler #(
  parameter int NUM_CAM      = 2,
  parameter int PIX_PER_BEAT = 2,
  parameter int TIMEOUT_W    = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 enable,
  input  logic [NUM_CAM-1:0]   cam_mask,
  input  logic [15:0]          lineWidth,
  input  logic [15:0]          frameHeight,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [NUM_CAM-1:0]   locked,
  input  logic [NUM_CAM-1:0]   frame_valid,
  input  logic [NUM_CAM-1:0]   new_frame,
  input  logic [NUM_CAM-1:0]   pixel_vld,
  output logic [NUM_CAM-1:0]   cameraSel,
  output logic [NUM_CAM-1:0]   camera_in_progress,
  output logic [2:0]           dma_sel,
  output logic                 frame_done,
  output logic [1:0]           frame_err,
  output logic [2:0]           done_cam,
  output logic [31:0]          frame_cnt,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [NUM_CAM-1:0] ONE     = NUM_CAM'(1);
  localparam logic [16:0]        PPB     = 17'(PIX_PER_BEAT);
  localparam logic [2:0]         LAST_IX = 3'(NUM_CAM - 1);

  logic [2:0]           state, state_nxt, rr_ptr, sel_idx;
  logic [1:0]           err_q, err_nxt;
  logic [15:0]          lw_q, fh_q, line_cnt;
  logic [16:0]          beat_cnt, beat_sum;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 fv_q, sel_found, wd_hit, line_wrap, last_line;
  logic                 g_locked, g_fv, g_nf, g_pv;
  logic [NUM_CAM-1:0]   elig;

  assign elig = cam_mask & locked;

  // cameraSel is one-hot while a camera is granted, so masking picks its strobes
  assign g_locked = |(locked & cameraSel);
  assign g_fv     = |(frame_valid & cameraSel);
  assign g_nf     = |(new_frame & cameraSel);
  assign g_pv     = |(pixel_vld & cameraSel);

  assign wd_hit    = (timeout_cycles != '0) && (wd_cnt >= timeout_cycles - TIMEOUT_W'(1));
  assign beat_sum  = beat_cnt + PPB;
  assign line_wrap = beat_sum >= {1'b0, lw_q};
  assign last_line = line_wrap && (({1'b0, line_cnt} + 17'd1) == {1'b0, fh_q});
  assign busy      = (state != S_IDLE);

  always_comb begin
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_CAM; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CAM) j = j - NUM_CAM;
      if (!sel_found && elig[j]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(j);
      end
    end
  end

  // Termination priority: lock loss, then timeout, then normal completion, then short frame
  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      S_IDLE:   if (enable && |elig) state_nxt = S_SELECT;
      S_SELECT: state_nxt = sel_found ? S_ARM : S_IDLE;
      S_ARM: begin
        if (!g_locked)   begin state_nxt = S_DONE; err_nxt = 2'd3; end
        else if (wd_hit) begin state_nxt = S_DONE; err_nxt = 2'd2; end
        else if (g_nf) begin
          if (lw_q == '0 || fh_q == '0) begin state_nxt = S_DONE; err_nxt = 2'd0; end
          else state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!g_locked)                begin state_nxt = S_DONE; err_nxt = 2'd3; end
        else if (wd_hit)              begin state_nxt = S_DONE; err_nxt = 2'd2; end
        else if (g_pv && last_line)   begin state_nxt = S_DONE; err_nxt = 2'd0; end
        else if (fv_q && !g_fv)       begin state_nxt = S_DONE; err_nxt = 2'd1; end
      end
      S_DONE:   state_nxt = enable ? S_SELECT : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state              <= S_IDLE;
      rr_ptr             <= '0;
      err_q              <= '0;
      lw_q               <= '0;
      fh_q               <= '0;
      beat_cnt           <= '0;
      line_cnt           <= '0;
      wd_cnt             <= '0;
      fv_q               <= 1'b0;
      cameraSel          <= '0;
      camera_in_progress <= '0;
      dma_sel            <= '0;
      frame_done         <= 1'b0;
      frame_err          <= '0;
      done_cam           <= '0;
      frame_cnt          <= '0;
    end else begin
      state      <= state_nxt;
      err_q      <= err_nxt;
      frame_done <= 1'b0;
      fv_q       <= g_fv;
      if (state_nxt != state || !(state == S_ARM || state == S_CAPTURE)) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      case (state)
        S_SELECT: if (sel_found) begin
          dma_sel   <= sel_idx;
          cameraSel <= ONE << sel_idx;
          lw_q      <= lineWidth;
          fh_q      <= frameHeight;
        end
        S_ARM: if (g_nf && g_locked && !wd_hit) begin
          camera_in_progress <= cameraSel;
          beat_cnt           <= '0;
          line_cnt           <= '0;
        end
        S_CAPTURE: if (g_pv) begin
          if (line_wrap) begin
            beat_cnt <= '0;
            line_cnt <= line_cnt + 16'd1;
          end else begin
            beat_cnt <= beat_sum;
          end
        end
        S_DONE: begin
          cameraSel          <= '0;
          camera_in_progress <= '0;
          frame_done         <= 1'b1;
          frame_err          <= err_q;
          done_cam           <= dma_sel;
          frame_cnt          <= frame_cnt + 32'd1;
          rr_ptr             <= (dma_sel >= LAST_IX) ? 3'd0 : dma_sel + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture_scheduler.sv
// Scoreboard bench for camera_capture_scheduler: expected frame results are queued
// as each frame is stimulated and retired by a monitor on every frame_done pulse.
module tb_camera_capture_scheduler;
  localparam int NUM_CAM = 2;
  localparam int TW      = 24;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic               enable;
  logic [NUM_CAM-1:0] cam_mask, locked, frame_valid, new_frame, pixel_vld;
  logic [15:0]        lineWidth, frameHeight;
  logic [TW-1:0]      timeout_cycles;
  logic [NUM_CAM-1:0] cameraSel, camera_in_progress;
  logic [2:0]         dma_sel, done_cam;
  logic               frame_done, busy;
  logic [1:0]         frame_err;
  logic [31:0]        frame_cnt;

  typedef struct { logic [1:0] err; logic [2:0] cam; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_err = 0, exp_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  camera_capture_scheduler #(.NUM_CAM(NUM_CAM), .PIX_PER_BEAT(2), .TIMEOUT_W(TW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .cam_mask(cam_mask),
    .lineWidth(lineWidth), .frameHeight(frameHeight), .timeout_cycles(timeout_cycles),
    .locked(locked), .frame_valid(frame_valid), .new_frame(new_frame), .pixel_vld(pixel_vld),
    .cameraSel(cameraSel), .camera_in_progress(camera_in_progress), .dma_sel(dma_sel),
    .frame_done(frame_done), .frame_err(frame_err), .done_cam(done_cam),
    .frame_cnt(frame_cnt), .busy(busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int err, input int cam);
    exp_t e;
    e.err = 2'(err);
    e.cam = 3'(cam);
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int cam);
    logic [NUM_CAM-1:0] want;
    int n;
    want = NUM_CAM'(1) << cam;
    n = 0;
    while (cameraSel !== want && n < 50) begin tick(); n++; end
    chk("grant", 32'(cameraSel), 32'(want));
    chk("dma_sel", 32'(dma_sel), 32'(cam));
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < budget) begin tick(); n++; end
    chk("done_seen", 32'(frame_done), 32'd1);
  endtask

  // new_frame, then back-to-back beats; optionally drop frame_valid with the last beat
  task automatic frame(input int cam, input int beats, input bit drop_on_last);
    new_frame[cam]   = 1'b1;
    frame_valid[cam] = 1'b1;
    tick();
    new_frame[cam] = 1'b0;
    chk("cip_on", 32'(camera_in_progress), 32'(NUM_CAM'(1) << cam));
    for (int b = 0; b < beats; b++) begin
      pixel_vld[cam] = 1'b1;
      if (drop_on_last && b == beats - 1) frame_valid[cam] = 1'b0;
      tick();
    end
    pixel_vld[cam]   = 1'b0;
    frame_valid[cam] = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst) begin
      exp_cnt = 0;
    end else begin
      chk("sel_onehot0", 32'($onehot0(cameraSel)), 32'd1);
      chk("cip_in_grant", 32'(camera_in_progress & ~cameraSel), 32'd0);
      if (frame_done) begin
        if (sb.size() == 0) begin
          chk("unexp_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          exp_cnt++;
          chk("frame_err", 32'(frame_err), 32'(e.err));
          chk("done_cam", 32'(done_cam), 32'(e.cam));
          chk("frame_cnt", frame_cnt, 32'(exp_cnt));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    sys_rst = 1'b1; enable = 1'b0; cam_mask = '1; locked = '1;
    frame_valid = '0; new_frame = '0; pixel_vld = '0;
    lineWidth = 16'd8; frameHeight = 16'd4; timeout_cycles = TW'(100);
    tick(); tick();
    chk("rst_sel", 32'(cameraSel), 0);
    chk("rst_cip", 32'(camera_in_progress), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_busy", 32'(busy), 0);
    sys_rst = 1'b0; enable = 1'b1;

    // full frame on cam0; frame_valid falls on the last beat, completion still wins
    wait_grant(0);
    push(0, 0);
    frame(0, 16, 1'b1);
    chk("done_lat_1", 32'(frame_done), 0);
    tick();
    chk("done_lat_2", 32'(frame_done), 1);
    wait_grant(1);

    // cam1 never starts: watchdog fires about 100 cycles after grant
    push(2, 1);
    wait_done(150, n);
    chk("tmo_window", 32'(n >= 95 && n <= 105), 1);
    chk("tmo_sel_clr", 32'(cameraSel), 0);
    timeout_cycles = TW'(20);

    wait_grant(0);
    push(0, 0);
    frame(0, 16, 1'b0);
    wait_done(5, n);

    // lock drops on exactly the cycle the capture watchdog expires
    wait_grant(1);
    push(3, 1);
    new_frame[1] = 1'b1; frame_valid[1] = 1'b1;
    tick();
    new_frame[1] = 1'b0;
    repeat (19) tick();
    locked[1] = 1'b0;
    wait_done(5, n);
    locked[1] = 1'b1; frame_valid[1] = 1'b0;

    // reset in the middle of a capture
    wait_grant(0);
    new_frame[0] = 1'b1; frame_valid[0] = 1'b1;
    tick();
    new_frame[0] = 1'b0; pixel_vld[0] = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b1; pixel_vld[0] = 1'b0; frame_valid[0] = 1'b0;
    tick();
    chk("mrst_sel", 32'(cameraSel), 0);
    chk("mrst_cip", 32'(camera_in_progress), 0);
    chk("mrst_dma", 32'(dma_sel), 0);
    chk("mrst_done", 32'(frame_done), 0);
    chk("mrst_err", 32'(frame_err), 0);
    chk("mrst_dcam", 32'(done_cam), 0);
    chk("mrst_cnt", frame_cnt, 0);
    chk("mrst_busy", 32'(busy), 0);
    sys_rst = 1'b0;

    // short frame: frame_valid falls after two lines
    wait_grant(0);
    push(1, 0);
    frame(0, 8, 1'b0);
    wait_done(5, n);
    wait_grant(1);

    // mask cam1 out; its in-flight grant times out, then only cam0 is served
    cam_mask = 2'b01;
    push(2, 1);
    wait_done(30, n);
    wait_grant(0);
    new_frame[1] = 1'b1;
    tick();
    new_frame[1] = 1'b0;
    chk("ign_cip", 32'(camera_in_progress), 0);
    chk("ign_sel", 32'(cameraSel), 32'd1);
    push(0, 0);
    frame(0, 16, 1'b0);
    wait_done(5, n);
    wait_grant(0);
    push(0, 0);
    frame(0, 16, 1'b0);
    wait_done(5, n);

    // zero frame height completes right after new_frame; enable low -> idle afterwards
    frameHeight = 16'd0;
    enable = 1'b0;
    wait_grant(0);
    push(0, 0);
    new_frame[0] = 1'b1; frame_valid[0] = 1'b1;
    tick();
    new_frame[0] = 1'b0;
    wait_done(5, n);
    frame_valid[0] = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sel", 32'(cameraSel), 0);
    tick(); tick();
    chk("idle_stay", 32'(busy), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
